// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the instruction-memory port arbiter: data/address
//   widths, the 2-bit arbiter state encoding and a width helper that never
//   returns zero (so single-entry configurations still get a 1-bit field).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_e;

    // Width of an index/counter able to hold 0..value-1, minimum 1 bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches the request vector starting at
//   ptr_i+1 and wrapping modulo N; the first set request wins.
//
// Ports
//   req_i    in   N    request vector
//   ptr_i    in   PW   last served index (search starts one above it)
//   grant_o  out  N    one-hot grant (all zero when nothing requests)
//   found_o  out  1    at least one request was present
// -----------------------------------------------------------------------------
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          found_o
);

    always_comb begin : pick
        int            idx_int;
        logic [PW-1:0] idx;
        // NOTE: every variable written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        grant_o = '0;
        found_o = 1'b0;
        idx_int = 0;
        idx     = '0;
        // k = 1..N visits ptr+1 first and ptr itself last.
        for (int k = 1; k <= N; k++) begin
            idx_int = int'(ptr_i) + k;
            if (idx_int >= N) begin
                idx_int = idx_int - N;
            end
            idx = PW'(idx_int);
            if (!found_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single instruction-memory read port between NUM_REQ requesters
//   (e.g. icache refill and decompressor dictionary fetch). One request is
//   issued per grant; arbitration is round-robin. Sequence per beat:
//   IDLE (pick) -> ISSUE (wait for memory) -> DRAIN (one bubble) -> IDLE.
//
//   Build option ARB_LOCK_EN: the first grant locks the port to its owner for
//   BURST_LEN beats (a line refill). Between beats the FSM sits in LOCKED and
//   only the owner may reissue; if the owner stays silent for LOCK_TIMEOUT
//   cycles the lock is abandoned. Without the macro, arbitration is per beat.
//
// Ports
//   clk            in   1            clock, rising edge
//   reset          in   1            asynchronous active-high reset
//   req_valid      in   NUM_REQ      per-requester request, held until req_ready
//   req_addr       in   NUM_REQ*32   word addresses, slice i = [32*i +: 32]
//   req_ready      out  NUM_REQ      data-valid pulse to the owner only
//   req_rdata      out  32           read data broadcast, valid with req_ready
//   mem_req_valid  out  1            registered request to memory
//   mem_req_ready  in   1            memory data-valid pulse
//   mem_req_addr   out  32           registered address to memory
//   mem_req_rdata  in   32           memory read data
//   grant_id       out  GW           current or last owner
//   busy           out  1            FSM not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int NUM_REQ      = 2,
    parameter  int BURST_LEN    = 4,
    parameter  int LOCK_TIMEOUT = 8,
    localparam int GW           = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic [DATA_W-1:0]         mem_req_rdata,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
);

    arb_state_e          state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  pick_oh;
    logic                pick_found;
    logic [GW-1:0]       pick_idx;

`ifdef ARB_LOCK_EN
    localparam int BW = clog2_min1(BURST_LEN);
    localparam int IW = clog2_min1(LOCK_TIMEOUT + 1);

    // beat_q != 0 after a ready means more beats remain in the burst.
    logic [BW-1:0] beat_q, beat_d;
    logic [IW-1:0] idle_q, idle_d;
`else
    // Burst/timeout parameters only shape the locked build.
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(BURST_LEN + LOCK_TIMEOUT);
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
        // Only the owner sees the memory pulse, and only while a request is out.
        assign req_ready[g] = (state_q == ST_ISSUE) && mem_req_ready && (grant_q == GW'(g));
    end

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .found_o (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = GW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        valid_d = valid_q;
`ifdef ARB_LOCK_EN
        beat_d  = beat_q;
        idle_d  = idle_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
`ifdef ARB_LOCK_EN
                    beat_d  = '0;
`endif
                end
            end

            ST_ISSUE: begin
                // A requester dropping valid here does not abort the request.
                if (mem_req_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_DRAIN;
`ifdef ARB_LOCK_EN
                    if (int'(beat_q) < BURST_LEN - 1) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        beat_d = '0;
                        ptr_d  = grant_q;
                    end
`else
                    ptr_d   = grant_q;
`endif
                end
            end

            ST_DRAIN: begin
`ifdef ARB_LOCK_EN
                if (beat_q != '0) begin
                    state_d = ST_LOCKED;
                    idle_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_LOCKED: begin
`ifdef ARB_LOCK_EN
                if (req_valid[grant_q]) begin
                    addr_d  = addr_arr[grant_q];
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                    idle_d  = '0;
                end else if (int'(idle_q) == LOCK_TIMEOUT - 1) begin
                    // Owner abandoned the burst: release and advance the pointer.
                    state_d = ST_IDLE;
                    ptr_d   = grant_q;
                    beat_d  = '0;
                    idle_d  = '0;
                end else begin
                    idle_d  = idle_q + 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
            beat_q  <= '0;
            idle_q  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
`ifdef ARB_LOCK_EN
            beat_q  <= beat_d;
            idle_q  <= idle_d;
`endif
        end
    end

    assign mem_req_valid = valid_q;
    assign mem_req_addr  = addr_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign req_rdata     = mem_req_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (NUM_REQ=2, BURST_LEN=4,
//   LOCK_TIMEOUT=8). Inputs change 1 ns after the rising edge; outputs are
//   sampled 1-2 ns after it. Build with ARB_LOCK_EN to exercise burst locking.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*32-1:0]   req_addr;
    logic [NUM_REQ-1:0]      req_ready;
    logic [31:0]             req_rdata;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [31:0]             mem_req_addr;
    logic [31:0]             mem_req_rdata;
    logic                    grant_id;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;
    int w;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ      (2),
        .BURST_LEN    (4),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .req_rdata     (req_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_rdata (mem_req_rdata),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a memory request, then check owner and address.
    // waits = number of rising edges until mem_req_valid was seen.
    task automatic wait_grant(input string tag, input int exp_g, input logic [31:0] exp_addr,
                              output int waits);
        waits = 0;
        while (!mem_req_valid && waits < 20) begin
            step();
            waits++;
        end
        check({tag, " valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, " grant"}, 32'(grant_id), 32'(exp_g));
        check({tag, " addr"}, mem_req_addr, exp_addr);
    endtask

    // Hold the request for 'hold' cycles, pulse memory ready with 'data',
    // and check routing plus the DRAIN bubble that follows.
    task automatic complete(input string tag, input int exp_g, input int hold,
                            input logic [31:0] data);
        logic [31:0] one_hot;
        one_hot = 32'd1 << exp_g;
        repeat (hold) step();
        check({tag, " held"}, {29'd0, mem_req_valid, req_ready}, {29'd0, 1'b1, 2'b00});
        mem_req_ready = 1'b1;
        mem_req_rdata = data;
        #1;
        check({tag, " ready"}, 32'(req_ready), one_hot);
        check({tag, " rdata"}, req_rdata, data);
        step();
        mem_req_ready = 1'b0;
        mem_req_rdata = '0;
        check({tag, " drain"}, {28'd0, busy, mem_req_valid, req_ready}, {28'd0, 4'b1000});
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        mem_req_rdata = '0;
        step();
        step();
        check("rst valid", 32'(mem_req_valid), 32'd0);
        check("rst addr",  mem_req_addr,       32'd0);
        check("rst grant", 32'(grant_id),      32'd0);
        check("rst busy",  32'(busy),          32'd0);
        check("rst ready", 32'(req_ready),     32'd0);
        reset = 1'b0;

`ifndef ARB_LOCK_EN
        // 1: single request, memory answers 3 cycles after the request.
        req_addr[31:0] = 32'h100;
        req_valid      = 2'b01;
        wait_grant("t1", 0, 32'h100, w);
        check("t1 latency", 32'(w), 32'd1);
        complete("t1", 0, 2, 32'hDEADBEEF);
        req_valid = 2'b00;
        step();
        check("t1 idle", {30'd0, busy, mem_req_valid}, 32'd0);

        // 2: simultaneous requests after reset -> strict alternation 0,1,0,1.
        do_reset();
        req_addr  = {32'h120, 32'h110};
        req_valid = 2'b11;
        wait_grant("t2a", 0, 32'h110, w);
        complete("t2a", 0, 0, 32'hA0);
        req_valid[0] = 1'b0;
        wait_grant("t2b", 1, 32'h120, w);
        check("t2b spacing", 32'(w), 32'd2);
        complete("t2b", 1, 0, 32'hA1);
        req_valid = 2'b11;
        wait_grant("t2c", 0, 32'h110, w);
        check("t2c spacing", 32'(w), 32'd2);
        complete("t2c", 0, 1, 32'hA2);
        req_valid[0] = 1'b0;
        wait_grant("t2d", 1, 32'h120, w);
        complete("t2d", 1, 0, 32'hA3);

        // 3: req1 drops valid mid-ISSUE; the beat still completes to req1.
        req_addr[63:32] = 32'h300;
        req_valid       = 2'b10;
        wait_grant("t3", 1, 32'h300, w);
        req_valid = 2'b00;
        complete("t3", 1, 1, 32'hCAFE0003);
        repeat (3) step();
        check("t3 no respin", {30'd0, busy, mem_req_valid}, 32'd0);
        req_addr  = {32'h440, 32'h400};
        req_valid = 2'b11;
        wait_grant("t3 next", 0, 32'h400, w);
        complete("t3 next", 0, 0, 32'hB0);
        req_valid[0] = 1'b0;
        wait_grant("t3 tail", 1, 32'h440, w);
        complete("t3 tail", 1, 0, 32'hB1);
        req_valid = 2'b00;
        step();

        // 4: stray memory ready in IDLE, then async reset in the middle of ISSUE.
        mem_req_ready = 1'b1;
        #1;
        check("t4 idle ready", 32'(req_ready), 32'd0);
        step();
        check("t4 idle state", {30'd0, busy, mem_req_valid}, 32'd0);
        mem_req_ready    = 1'b0;
        req_addr[63:32]  = 32'h500;
        req_valid        = 2'b10;
        wait_grant("t4", 1, 32'h500, w);
        #2;
        reset = 1'b1;
        #1;
        check("t4 rst valid", 32'(mem_req_valid), 32'd0);
        check("t4 rst addr",  mem_req_addr,       32'd0);
        check("t4 rst grant", 32'(grant_id),      32'd0);
        check("t4 rst busy",  32'(busy),          32'd0);
        mem_req_ready = 1'b1;
        req_valid     = 2'b00;
        #1;
        check("t4 rst ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("t4 late ready", {29'd0, busy, req_ready}, 32'd0);
        mem_req_ready = 1'b0;
        req_addr      = {32'h520, 32'h510};
        req_valid     = 2'b11;
        wait_grant("t4 rr", 0, 32'h510, w);
        complete("t4 rr", 0, 0, 32'hC0);
        req_valid = 2'b00;
`else
        // 5: req0 locks the port for 4 beats at 0x200..0x20C; req1 waits.
        req_addr  = {32'h900, 32'h200};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("t5 beat%0d", k), 0, 32'h200 + 32'(4 * k), w);
            if (k > 0) check($sformatf("t5 beat%0d gap", k), 32'(w), 32'd2);
            complete($sformatf("t5 beat%0d", k), 0, 1, 32'hD0 + 32'(k));
            if (k < 3) req_addr[31:0] = 32'h200 + 32'(4 * (k + 1));
            else       req_valid[0]   = 1'b0;
        end
        wait_grant("t5 req1", 1, 32'h900, w);
        check("t5 req1 gap", 32'(w), 32'd2);
        complete("t5 req1", 1, 0, 32'hE0);
        req_valid = 2'b00;

        // 6: req0 stops after 2 beats; after DRAIN, 8 silent LOCKED cycles,
        //    then IDLE picks req1: request appears on the 10th edge.
        do_reset();
        req_addr  = {32'h900, 32'h200};
        req_valid = 2'b11;
        wait_grant("t6 beat0", 0, 32'h200, w);
        complete("t6 beat0", 0, 0, 32'hF0);
        req_addr[31:0] = 32'h204;
        wait_grant("t6 beat1", 0, 32'h204, w);
        complete("t6 beat1", 0, 0, 32'hF1);
        req_valid[0] = 1'b0;
        wait_grant("t6 timeout", 1, 32'h900, w);
        check("t6 timeout gap", 32'(w), 32'd10);
        complete("t6 req1", 1, 0, 32'hF2);
        req_valid = 2'b00;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
